// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: Execute-stage forwarding selects,
// load-use stall and branch flush, tracked from a registered shadow of E/M/W register fields.
module hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LoadD,
    input  logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE
);

    logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
    logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
    logic [REG_AW-1:0] rd_e_q, rd_e_d;
    logic              regwrite_e_q, regwrite_e_d;
    logic              load_e_q, load_e_d;
    logic [REG_AW-1:0] rd_m_q, rd_w_q;
    logic              regwrite_m_q, regwrite_w_q;
    logic              lw_stall;

    // Memory result is younger than Writeback, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              rw_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              rw_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (rw_m && (rd_m == rs)) begin
                sel = 2'b10;
            end else if (rw_w && (rd_w == rs)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign ForwardAE = fwd_sel(rs1_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
    assign ForwardBE = fwd_sel(rs2_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);

    // Rs2D is compared even when the Decode instruction has no rs2 (conservative stall).
    assign lw_stall = load_e_q & regwrite_e_q & (rd_e_q != '0) &
                      ((Rs1D == rd_e_q) | (Rs2D == rd_e_q));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (reset_n) begin
            StallF = lw_stall & ~PCSrcE;
            StallD = lw_stall & ~PCSrcE;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
        end
    end

    always_comb begin
        rs1_e_d      = Rs1D;
        rs2_e_d      = Rs2D;
        rd_e_d       = RdD;
        regwrite_e_d = RegWriteD;
        load_e_d     = LoadD;
        if (FlushE) begin
            rs1_e_d      = '0;
            rs2_e_d      = '0;
            rd_e_d       = '0;
            regwrite_e_d = 1'b0;
            load_e_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rs1_e_q      <= '0;
            rs2_e_q      <= '0;
            rd_e_q       <= '0;
            regwrite_e_q <= 1'b0;
            load_e_q     <= 1'b0;
            rd_m_q       <= '0;
            regwrite_m_q <= 1'b0;
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
        end else begin
            rs1_e_q      <= rs1_e_d;
            rs2_e_q      <= rs2_e_d;
            rd_e_q       <= rd_e_d;
            regwrite_e_q <= regwrite_e_d;
            load_e_q     <= load_e_d;
            rd_m_q       <= rd_e_q;
            regwrite_m_q <= regwrite_e_q;
            rd_w_q       <= rd_m_q;
            regwrite_w_q <= regwrite_m_q;
        end
    end

endmodule
